// File: rtl/apb_mem_slave.sv
// apb_mem_slave: parametrised APB memory target with byte strobes,
// programmable wait states, out-of-range error response and transfer abort.
// Optional feature macro: APB_MEM_RO_EN (words 0..RO_WORDS-1 become read-only).
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 4
) (
  input  logic                    pclk_i,
  input  logic                    prst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef APB_MEM_RO_EN
  localparam logic RO_EN = 1'b1;
`else
  localparam logic RO_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                  state_r;
  logic [3:0]              cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    write_r;
  logic                    err_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_W-1:0]       strb_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic                    in_range_s;
  logic                    ro_hit_s;
  logic                    setup_s;
  logic                    pready_s;
  logic                    complete_s;
  logic [IDX_W-1:0]        rd_idx_s;

  // Address decode happens on the live bus only at the setup edge; the
  // resulting error flag and index are captured for the whole access.
  assign in_range_s = (int'(paddr_i) < MEM_DEPTH);
  assign ro_hit_s   = RO_EN & pwrite_i & (int'(paddr_i) < RO_WORDS);
  assign rd_idx_s   = paddr_i[IDX_W-1:0];
  assign setup_s    = (state_r == IDLE) & psel_i & ~penable_i;

  // pready is decoded from registered state only, so it cannot glitch on bus inputs.
  assign pready_s   = (state_r == ACCESS) & (cnt_r == 4'd0);
  assign complete_s = pready_s & psel_i & penable_i;

  assign pready_o   = pready_s;
  assign pslverr_o  = pready_s & err_r;

  // Transfer FSM: captures the request at setup, counts wait states, handles abort.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      idx_r    <= '0;
      write_r  <= 1'b0;
      err_r    <= 1'b0;
      wdata_r  <= '0;
      strb_r   <= '0;
      prdata_o <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            state_r <= ACCESS;
            cnt_r   <= WAIT_INIT;
            idx_r   <= rd_idx_s;
            write_r <= pwrite_i;
            err_r   <= ~in_range_s | ro_hit_s;
            wdata_r <= pwdata_i;
            strb_r  <= pstrb_i;
            if (!pwrite_i) begin
              prdata_o <= in_range_s ? mem_r[rd_idx_s] : '0;
            end
          end
        end
        ACCESS: begin
          if (!psel_i) begin
            state_r <= IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (penable_i) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Memory array: cleared on reset, byte-lane write on a completed error-free write.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (complete_s && write_r && !err_r) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_r[b]) begin
          mem_r[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: the driver pushes expected responses
// computed from a word-array model; a negedge monitor pops and compares.
module tb_apb_mem_slave;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 8;
  localparam int W     = 3;
  localparam int ROW   = 4;

`ifdef APB_MEM_RO_EN
  localparam bit RO_EN_TB = 1'b1;
`else
  localparam bit RO_EN_TB = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_rd = '0;
  int            compared = 0;
  int            failed = 0;
  int            wait_cnt = 0;

  apb_mem_slave #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .WAIT_STATES(W), .RO_WORDS(ROW)
  ) dut (
    .pclk_i(clk), .prst_i(rst), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: compute the response of one transfer and update the model.
  task automatic push_expect(input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [3:0] s);
    exp_t e;
    logic oor;
    logic ro;
    oor = (int'(a) >= DEPTH);
    ro  = RO_EN_TB && wr && (int'(a) < ROW);
    e.err = oor || ro;
    if (!wr) begin
      last_rd = oor ? '0 : model_mem[a];
    end else if (!e.err) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
      end
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
  endtask

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
    logic got;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    push_expect(wr, a, d, s);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = AW'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = pready;
    end
    if (!got) begin
      compared++; failed++;
      $display("FAIL timeout: pready never rose for addr %0d", a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  // Monitor: counts wait cycles of each access and checks every completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst || !(psel && penable)) begin
      wait_cnt = 0;
    end else if (!pready) begin
      wait_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        compared++; failed++;
        $display("FAIL unexpected completion: got pready=1 expected no transfer");
      end else begin
        e = exp_q.pop_front();
        chk("prdata", prdata, e.rdata);
        chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
        chk("wait_cycles", wait_cnt, W);
      end
      wait_cnt = 0;
    end
    if (!rst && !pready) chk("pslverr_without_pready", {31'd0, pslverr}, 32'd0);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_prdata", prdata, 32'd0);
    chk("reset_pready", {31'd0, pready}, 32'd0);
    chk("reset_pslverr", {31'd0, pslverr}, 32'd0);
    rst = 1'b0;

    // Basic write/read
    apb_xfer(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    apb_xfer(1'b0, 8'd5, 32'h0, 4'h0);
    idle(2);

    // Byte strobes
    apb_xfer(1'b1, 8'd2, 32'h11223344, 4'hF);
    apb_xfer(1'b1, 8'd2, 32'hAABBCCDD, 4'h5);
    apb_xfer(1'b0, 8'd2, 32'h0, 4'h0);
    chk("strobe_merge_model", model_mem[2], 32'h11BB33DD);
    apb_xfer(1'b0, 8'd1, 32'h0, 4'h0);

    // Zero strobe
    apb_xfer(1'b1, 8'd5, 32'h01020304, 4'h0);
    apb_xfer(1'b0, 8'd5, 32'h0, 4'h0);

    // Out of range, then scan that all words are intact
    apb_xfer(1'b1, 8'd16, 32'hFFFFFFFF, 4'hF);
    apb_xfer(1'b0, 8'd16, 32'h0, 4'h0);
    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b0, AW'(i), 32'h0, 4'h0);
    idle(1);

    // Read-only region (errors only when the feature is built in)
    apb_xfer(1'b1, 8'd3, 32'h00001234, 4'hF);
    apb_xfer(1'b0, 8'd3, 32'h0, 4'h0);
    apb_xfer(1'b1, 8'd4, 32'h00001234, 4'hF);
    apb_xfer(1'b0, 8'd4, 32'h0, 4'h0);
    idle(1);

    // Enable without a setup phase is ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_setup_pready", {31'd0, pready}, 32'd0);
    end
    chk("no_setup_prdata", prdata, last_rd);
    idle(1);

    // Abort: psel dropped in the second access cycle
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_pready", {31'd0, pready}, 32'd0);
    apb_xfer(1'b0, 8'd7, 32'h0, 4'h0);
    idle(1);

    // Randomised traffic with occasional idle gaps
    for (int n = 0; n < 150; n++) begin
      apb_xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), $urandom,
               4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset asserted mid-access of a write
    apb_xfer(1'b1, 8'd9, 32'h5A5A5A5A, 4'hF);
    apb_xfer(1'b0, 8'd9, 32'h0, 4'h0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset_prdata", prdata, 32'd0);
    chk("midreset_pready", {31'd0, pready}, 32'd0);
    chk("midreset_pslverr", {31'd0, pslverr}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    last_rd = '0;
    apb_xfer(1'b0, 8'd9, 32'h0, 4'h0);
    apb_xfer(1'b0, 8'd5, 32'h0, 4'h0);
    apb_xfer(1'b0, 8'd2, 32'h0, 4'h0);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- Parametrised APB slave memory; next generation of the team's 8-bit, 16-deep APB memory DUT.
- Adds configurable data width and depth, byte strobes (pstrb), programmable wait states, out-of-range error response and transfer abort.
- Sits behind the APB bus as the standard memory target for the apb_env verification environment.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; must be a multiple of 8; STRB_W = DATA_WIDTH/8.
- MEM_DEPTH, 16: number of words; any value >= 2, need not be a power of 2.
- ADDR_WIDTH, 8: word-address width; must be >= $clog2(MEM_DEPTH).
- WAIT_STATES, 0: access-phase cycles with pready_o low before completion; range 0..15.
- RO_WORDS, 4: count of read-only words at addresses 0..RO_WORDS-1; used only with APB_MEM_RO_EN.

Ports:
- pclk_i  in  1  clock; all state updates on the rising edge.
- prst_i  in  1  reset; asynchronous, active-high.
- psel_i  in  1  slave select.
- penable_i  in  1  access-phase indicator.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_WIDTH  word address.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  STRB_W  byte-lane write strobes.
- prdata_o  out  DATA_WIDTH  read data.
- pready_o  out  1  transfer completion.
- pslverr_o  out  1  error response; valid only while pready_o = 1.

Behaviour:
- Interface: one clock (pclk_i); reset prst_i is asynchronous and active-high.
- Reset (async assert; deassertion is synchronised externally):
  - state = IDLE, wait counter = 0.
  - prdata_o = 0, pready_o = 0, pslverr_o = 0.
  - All memory words cleared to 0.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - A setup phase (psel_i = 1, penable_i = 0) moves to ACCESS.
  - On that edge, capture paddr_i, pwrite_i, pwdata_i, pstrb_i; load counter = WAIT_STATES.
  - Read setup also loads prdata_o with mem[paddr_i], or 0 if out of range.
  - psel_i = 1 with penable_i = 1 in IDLE (no setup phase) is ignored: stay IDLE, pready_o stays 0.
- ACCESS:
  - psel_i = 0: abort. Go to IDLE; no write, no error.
  - Counter != 0: decrement; pready_o = 0.
  - Counter == 0: pready_o = 1 (decoded from registered state and counter only, so glitch-free).
  - Completion edge is psel_i & penable_i & pready_o: perform the write if applicable, then go to IDLE.
- Latency: with WAIT_STATES = W, pready_o rises in the (W+1)th access cycle. W = 0 gives a zero-wait, 2-cycle APB transfer.
- Back-to-back: the cycle after completion the FSM is in IDLE, so a new setup phase is accepted immediately. No dead cycle beyond the APB minimum of 2 cycles per transfer.
- Write: for each lane b with strobe bit b = 1, mem[addr][8b+7:8b] = wdata byte b. Lanes with strobe 0 keep their value. All-zero strobe completes normally, memory unchanged, no error.
- Read: prdata_o holds its value until the next read setup. Writes do not change prdata_o.
- Out of range (captured address >= MEM_DEPTH):
  - pslverr_o = 1 together with pready_o.
  - No memory update; read returns prdata_o = 0.
- pslverr_o is 0 whenever pready_o is 0.
- Captured fields are used for the whole access. Master changes to paddr_i or pwdata_i mid-access have no effect.
- Reset asserted mid-transfer: immediate return to IDLE, outputs and memory cleared, partial write discarded.

Optional Feature:
- Macro: APB_MEM_RO_EN.
- Defined:
  - Words 0..RO_WORDS-1 are read-only.
  - A write to them completes with pslverr_o = 1 and leaves memory unchanged.
  - Reads are unaffected.
- Undefined: all in-range words are writable; the RO_WORDS parameter is ignored.

Test Plan:
- Defaults, W = 0: write 0xDEADBEEF to addr 5 with pstrb = 0xF, then read addr 5 -> pready_o high in the 2nd cycle of each transfer, prdata_o = 0xDEADBEEF, pslverr_o = 0.
- Byte strobes: addr 2 holds 0x11223344; write 0xAABBCCDD with pstrb = 0x5 -> read returns 0x11BB33DD.
- WAIT_STATES = 3: read addr 1 -> pready_o low for 3 access cycles and high in the 4th; prdata_o valid from the first access cycle.
- Out of range: write then read addr 16 (MEM_DEPTH = 16) -> pslverr_o = 1 with pready_o, read data 0, words 0..15 unchanged.
- Abort and reset: W = 5, drop psel_i in access cycle 2 -> no write, FSM IDLE. Separately, assert prst_i mid-access -> outputs 0 and memory read back as 0.
- With APB_MEM_RO_EN and RO_WORDS = 4: write 0x1234 to addr 3 -> pslverr_o = 1, read 0; write to addr 4 -> pslverr_o = 0, read 0x1234.
